// File: rtl/baud_nco.sv
// Numerically-controlled UART tick generator: oversample and bit-rate clock enables with run-time rate change.
// Optional build macro BAUD_NCO_SYNC_EN adds a 'sync' input for mid-bit receiver alignment.
module baud_nco #(
    parameter int ACC_W       = 24,
    parameter int OSR         = 16,
    parameter int DEFAULT_INC = 247391,
    parameter int LOCK_TICKS  = 4
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             cfg_valid,
`ifdef BAUD_NCO_SYNC_EN
    input  logic             sync,
`endif
    output logic             cfg_ready,
    output logic             tick_os,
    output logic             tick_baud,
    output logic             lock,
    output logic [ACC_W-1:0] inc_cur
);

    localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int SET_W = $clog2(LOCK_TICKS + 1);

    typedef enum logic [1:0] {OFF, SETTLE, LOCKED} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] pend_inc;
    logic [CNT_W-1:0] os_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             pending;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             baud_wrap;
    logic             accept;
    logic             do_sync;

    assign sum       = {1'b0, acc} + {1'b0, inc_cur};
    assign carry     = sum[ACC_W];
    assign baud_wrap = (os_cnt == CNT_W'(OSR - 1));
    assign cfg_ready = !pending;
    assign accept    = cfg_valid && !pending;

`ifdef BAUD_NCO_SYNC_EN
    assign do_sync = sync;
`else
    assign do_sync = 1'b0;
`endif

    // Phase accumulator and oversample counter; the carry out of the accumulator is the oversample event.
    always_ff @(posedge clkin) begin
        if (!reset_n || !enable) begin
            acc       <= '0;
            os_cnt    <= '0;
            tick_os   <= 1'b0;
            tick_baud <= 1'b0;
        end else if (do_sync) begin
            acc       <= '0;
            os_cnt    <= CNT_W'(OSR / 2);
            tick_os   <= 1'b0;
            tick_baud <= 1'b0;
        end else begin
            acc       <= sum[ACC_W-1:0];
            tick_os   <= carry;
            tick_baud <= carry && baud_wrap;
            if (carry) begin
                os_cnt <= baud_wrap ? '0 : os_cnt + 1'b1;
            end
        end
    end

    // Rate control: a new increment taken while running is held until a bit boundary so no bit is distorted.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state      <= OFF;
            lock       <= 1'b0;
            pending    <= 1'b0;
            pend_inc   <= '0;
            settle_cnt <= '0;
            inc_cur    <= ACC_W'(DEFAULT_INC);
        end else if (!enable) begin
            state      <= OFF;
            lock       <= 1'b0;
            settle_cnt <= '0;
            pending    <= 1'b0;
            if (pending) begin
                inc_cur <= pend_inc;
            end else if (accept) begin
                inc_cur <= cfg_inc;
            end
        end else begin
            case (state)
                OFF: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    lock       <= 1'b0;
                    if (accept) begin
                        inc_cur <= cfg_inc;
                    end
                end
                default: begin
                    if (accept) begin
                        pend_inc <= cfg_inc;
                        pending  <= 1'b1;
                    end
                    if (tick_baud && pending) begin
                        inc_cur    <= pend_inc;
                        pending    <= 1'b0;
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        lock       <= 1'b0;
                    end else if (state == SETTLE && tick_baud) begin
                        if (settle_cnt == SET_W'(LOCK_TICKS - 1)) begin
                            state      <= LOCKED;
                            lock       <= 1'b1;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
